// File: rtl/mem_pkg.sv
// Shared widths, FSM state type and helpers for the block memory stage.
package mem_pkg;

  localparam int WORD_BITS       = 32;
  localparam int BLOCK_BITS      = 128;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int OFFSET_BITS     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Down-counter width able to hold LATENCY-1; never narrower than one bit.
  function automatic int cntWidth(input int latency);
    return (latency < 2) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised backing store with a whole-block write port and a
// combinational whole-block read port, both addressed by block index.
module mem_array
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int IDX_W     = 6
) (
  input  logic                  clk,
  input  logic                  wrEn,
  input  logic [IDX_W-1:0]      blkIdx,
  input  logic [BLOCK_BITS-1:0] wrBlock,
  output logic [BLOCK_BITS-1:0] rdBlock
);

  localparam int WSEL_W = $clog2(WORDS_PER_BLOCK);

  // Not reset: contents start at zero and survive controller resets.
  logic [WORD_BITS-1:0] mem [MEM_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        mem[{blkIdx, WSEL_W'(i)}] <= wrBlock[i*WORD_BITS +: WORD_BITS];
      end
    end
  end

  for (genvar w = 0; w < WORDS_PER_BLOCK; w++) begin : gRead
    assign rdBlock[w*WORD_BITS +: WORD_BITS] = mem[{blkIdx, WSEL_W'(w)}];
  end

endmodule

// File: rtl/block_memory_ctrl.sv
// Main-memory stage behind the write-back cache: whole-block read/write
// requests with a req/ready handshake and a programmable access latency.
//
//   state | meaning
//   IDLE  | waiting for memReq; accepts and latches a request
//   BUSY  | latency down-counter running; access happens at count zero
//   DONE  | memReady pulse for the completed request
module block_memory_ctrl
  import mem_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int MEM_WORDS  = 256,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memReq,
  input  logic                  readWriteOut,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [BLOCK_BITS-1:0] writeDataMem,
  output logic [BLOCK_BITS-1:0] readDataMem,
  output logic                  memReady,
  output logic                  memBusy
);

  localparam int BLK_W = ADDR_WIDTH - OFFSET_BITS;
  localparam int CNT_W = cntWidth(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_t            state, stateNext;
  logic [CNT_W-1:0]      counter;
  logic [BLK_W-1:0]      blkLatch;
  logic                  rwLatch;
  logic [BLOCK_BITS-1:0] dataLatch;
  logic [BLOCK_BITS-1:0] arrayRdData;
  logic                  accept;
  logic                  finish;

  // Byte offset within the block is irrelevant for whole-block transfers.
  logic unusedAddrBits;
  assign unusedAddrBits = ^memAddr[OFFSET_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (memReq) begin
          stateNext = BUSY;
          accept    = 1'b1;
        end
      end
      BUSY: begin
        if (counter == '0) begin
          stateNext = DONE;
          finish    = 1'b1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign memReady = (state == DONE);
  assign memBusy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter     <= '0;
      blkLatch    <= '0;
      rwLatch     <= 1'b0;
      dataLatch   <= '0;
      readDataMem <= '0;
    end else begin
      if (accept) begin
        counter   <= CNT_LOAD;
        blkLatch  <= memAddr[ADDR_WIDTH-1:OFFSET_BITS];
        rwLatch   <= readWriteOut;
        dataLatch <= writeDataMem;
      end else if ((state == BUSY) && (counter != '0)) begin
        counter <= counter - 1'b1;
      end
      if (finish && !rwLatch) begin
        readDataMem <= arrayRdData;
      end
    end
  end

  mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (BLK_W)
  ) uArray (
    .clk     (clk),
    .wrEn    (finish && rwLatch),
    .blkIdx  (blkLatch),
    .wrBlock (dataLatch),
    .rdBlock (arrayRdData)
  );

endmodule

// File: tb/tb_block_memory_ctrl.sv
// Self-checking bench: table vectors, hand-written corner sequences and a
// randomized phase against a block-level reference model.
module tb_block_memory_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         memReq0, memReq1, readWriteOut;
  logic [9:0]   memAddr;
  logic [127:0] writeDataMem;
  logic [127:0] rd0, rd1;
  logic         rdy0, rdy1, busy0, busy1;

  int vecs = 0;
  int errs = 0;

  logic [127:0] refMem0 [64];
  logic [127:0] refMem1 [64];
  logic [127:0] refRd0, refRd1;

  always #5 clk = ~clk;

  block_memory_ctrl #(.LATENCY(4), .MEM_WORDS(256), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .memReq(memReq0), .readWriteOut(readWriteOut),
    .memAddr(memAddr), .writeDataMem(writeDataMem), .readDataMem(rd0),
    .memReady(rdy0), .memBusy(busy0)
  );

  block_memory_ctrl #(.LATENCY(1), .MEM_WORDS(256), .ADDR_WIDTH(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .memReq(memReq1), .readWriteOut(readWriteOut),
    .memAddr(memAddr), .writeDataMem(writeDataMem), .readDataMem(rd1),
    .memReady(rdy1), .memBusy(busy1)
  );

  typedef struct {
    logic         rw;
    logic [9:0]   addr;
    logic [127:0] data;
    logic [127:0] expRd;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One request from an IDLE negedge; returns at a negedge with the DUT idle.
  task automatic doTxn(input bit sel, input logic rw, input logic [9:0] a,
                       input logic [127:0] d, input int lat,
                       input logic [127:0] expRd, input bit wiggle);
    int n = 0;
    int busyN = 0;
    bit seen = 1'b0;
    readWriteOut = rw;
    memAddr      = a;
    writeDataMem = d;
    if (sel) memReq1 = 1'b1; else memReq0 = 1'b1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      memReq0 = 1'b0;
      memReq1 = 1'b0;
      if (wiggle) begin
        memAddr      = 10'($urandom);
        writeDataMem = {$urandom, $urandom, $urandom, $urandom};
        readWriteOut = 1'($urandom_range(0, 1));
      end
      if (sel ? busy1 : busy0) busyN++;
      if (sel ? rdy1 : rdy0) seen = 1'b1;
    end
    chk("latency", 128'(n), 128'(lat + 1));
    chk("busyCycles", 128'(busyN), 128'(lat + 1));
    chk("readData", sel ? rd1 : rd0, expRd);
    @(negedge clk);
    chk("readyPulse", 128'(sel ? rdy1 : rdy0), 128'(0));
    chk("busyAfter", 128'(sel ? busy1 : busy0), 128'(0));
  endtask

  task automatic modelTxn(input logic rw, input logic [9:0] a, input logic [127:0] d);
    logic [127:0] exp;
    exp = rw ? refRd0 : refMem0[a[9:4]];
    doTxn(1'b0, rw, a, d, 4, exp, 1'b0);
    if (rw) refMem0[a[9:4]] = d;
    else    refRd0 = exp;
  endtask

  initial begin
    logic [127:0] blkD, blkY, blkT, blkW;
    int accN, rdyN, acc1, acc2, c;
    bit prevBusy;

    blkD = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    blkY = 128'h0F0F0F0F_12345678_9ABCDEF0_55AA55AA;
    tbl[0] = '{1'b1, 10'h030, blkD, 128'h0};
    tbl[1] = '{1'b0, 10'h03C, 128'h0, blkD};
    tbl[2] = '{1'b0, 10'h3F0, 128'h0, 128'h0};
    tbl[3] = '{1'b1, 10'h2A5, 128'h11111111_22222222_33333333_44444444, 128'h0};
    tbl[4] = '{1'b0, 10'h2AF, 128'h0, 128'h11111111_22222222_33333333_44444444};
    tbl[5] = '{1'b1, 10'h3FC, blkY, 128'h11111111_22222222_33333333_44444444};
    tbl[6] = '{1'b0, 10'h3F0, 128'h0, blkY};

    for (int i = 0; i < 64; i++) begin
      refMem0[i] = '0;
      refMem1[i] = '0;
    end
    refRd0 = '0;
    refRd1 = '0;

    rst_n = 1'b0;
    memReq0 = 1'b0;
    memReq1 = 1'b0;
    readWriteOut = 1'b0;
    memAddr = '0;
    writeDataMem = '0;
    repeat (3) @(negedge clk);
    chk("rstReadData", rd0, 128'h0);
    chk("rstReady", 128'(rdy0), 128'h0);
    chk("rstBusy", 128'(busy0), 128'h0);
    chk("rstReadData1", rd1, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      doTxn(1'b0, tbl[i].rw, tbl[i].addr, tbl[i].data, 4, tbl[i].expRd, 1'b0);
      if (tbl[i].rw) refMem0[tbl[i].addr[9:4]] = tbl[i].data;
      else           refRd0 = refMem0[tbl[i].addr[9:4]];
      if (i == 1) chk("word0Packing", 128'(rd0[31:0]), 128'hAAAAAAAA);
    end

    // memReq held high across two reads of different blocks
    readWriteOut = 1'b0;
    memAddr = 10'h030;
    memReq0 = 1'b1;
    accN = 0; rdyN = 0; acc1 = 0; acc2 = 0; prevBusy = 1'b0;
    for (c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (busy0 && !prevBusy) begin
        accN++;
        if (accN == 1) begin
          acc1 = c;
          memAddr = 10'h3F0;
        end else begin
          acc2 = c;
          memReq0 = 1'b0;
        end
      end
      if (rdy0) begin
        rdyN++;
        chk("heldReqData", rd0, (rdyN == 1) ? blkD : blkY);
      end
      prevBusy = busy0;
    end
    memReq0 = 1'b0;
    chk("heldReqAccepts", 128'(accN), 128'(2));
    chk("heldReqSpacing", 128'(acc2 - acc1), 128'(6));
    chk("heldReqReadies", 128'(rdyN), 128'(2));
    refRd0 = blkY;

    // Inputs wiggled during BUSY must not disturb the latched write
    blkT = 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF;
    doTxn(1'b0, 1'b1, 10'h100, blkT, 4, refRd0, 1'b1);
    refMem0[6'h10] = blkT;
    modelTxn(1'b0, 10'h10A, '0);

    // Reset in the middle of a write to block 5
    readWriteOut = 1'b1;
    memAddr = 10'h050;
    writeDataMem = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    memReq0 = 1'b1;
    @(negedge clk);
    memReq0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midRstReadData", rd0, 128'h0);
    chk("midRstReady", 128'(rdy0), 128'h0);
    chk("midRstBusy", 128'(busy0), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    refRd0 = '0;
    refRd1 = '0;
    rdyN = 0;
    repeat (8) begin
      @(negedge clk);
      if (rdy0) rdyN++;
    end
    chk("abortedReady", 128'(rdyN), 128'h0);
    modelTxn(1'b0, 10'h050, '0);

    // LATENCY = 1 instance
    blkW = 128'h76543210_FEDCBA98_A5A5A5A5_3C3C3C3C;
    doTxn(1'b1, 1'b1, 10'h010, blkW, 1, refRd1, 1'b0);
    refMem1[1] = blkW;
    doTxn(1'b1, 1'b0, 10'h01C, '0, 1, refMem1[1], 1'b0);
    refRd1 = refMem1[1];

    // Randomized traffic against the block-level model
    for (int i = 0; i < 40; i++) begin
      modelTxn(1'($urandom_range(0, 1)), 10'($urandom),
               {$urandom, $urandom, $urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
